// File: rtl/clk_ctrl_seq_pkg.sv
// Shared types for the dut clock sequencer: command opcodes, sequencer states
// and the clock-control bundle consumed by test_if.
package clk_ctrl_seq_pkg;

    typedef enum logic [1:0] {
        HALT     = 2'd0,
        FREE_RUN = 2'd1,
        RUN_N    = 2'd2,
        STEP_N   = 2'd3
    } clk_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        FREE,
        DRAIN,
        RUN,
        STEP_HI,
        STEP_LO
    } seq_state_e;

    // test_if derives dut_clk = nEnable & (manual ? clk : tb_clk)
    typedef struct packed {
        logic manual;
        logic clk;
        logic nEnable;
    } clk_ctrl_t;

endpackage

// File: rtl/clk_ctrl_seq.sv
// Command-driven sequencer producing the clk_ctrl_t bundle for test_if:
// halt, free-run, run exactly N tb_clk cycles, or step N manual pulses.
module clk_ctrl_seq
    import clk_ctrl_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             tb_clk,
    input  logic             nReset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  clk_cmd_e         cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [CNT_W-1:0] cmd_half,
    output clk_ctrl_t        ctrl_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edges
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] pulseCnt_q, pulseCnt_d;
    logic [CNT_W-1:0] halfCnt_q, halfCnt_d;
    logic [CNT_W-1:0] halfLoad_q, halfLoad_d;
    logic [CNT_W-1:0] edges_q, edges_d;
    logic [CNT_W-1:0] heldCount_q, heldCount_d;
    logic [CNT_W-1:0] heldHalf_q, heldHalf_d;
    clk_cmd_e         heldOp_q, heldOp_d;
    logic             clk_q, clk_d;
    logic             manual_q, manual_d;
    logic             done_q, done_d;
    logic             finish_q, finish_d;
    logic             ready_q;
    logic             nEnable_q;

    logic             accept;
    logic             enable;
    logic             launch;
    clk_cmd_e         launchOp;
    logic [CNT_W-1:0] launchCount;
    logic [CNT_W-1:0] launchHalf;
    logic [CNT_W-1:0] launchH;

    assign cmd_ready = ready_q && (state_q == IDLE || state_q == FREE);
    assign accept    = cmd_valid && cmd_ready;
    assign enable    = (state_q == FREE) || (state_q == RUN) ||
                       (state_q == STEP_LO) || (state_q == STEP_HI);
    assign busy      = (state_q == RUN) || (state_q == STEP_LO) ||
                       (state_q == STEP_HI) || (state_q == DRAIN && finish_q);
    assign done      = done_q;
    assign edges     = edges_q;
    assign ctrl_o    = '{manual: manual_q, clk: clk_q, nEnable: nEnable_q};

    // A command starts either straight from IDLE or from the command held across DRAIN.
    always_comb begin
        launch      = 1'b0;
        launchOp    = cmd_op;
        launchCount = cmd_count;
        launchHalf  = cmd_half;
        if (state_q == IDLE) begin
            launch = accept;
        end else if (state_q == DRAIN && !finish_q) begin
            launch      = 1'b1;
            launchOp    = heldOp_q;
            launchCount = heldCount_q;
            launchHalf  = heldHalf_q;
        end
        launchH = (launchHalf == '0) ? ONE : launchHalf;
    end

    always_comb begin
        state_d     = state_q;
        pulseCnt_d  = pulseCnt_q;
        halfCnt_d   = halfCnt_q;
        halfLoad_d  = halfLoad_q;
        edges_d     = edges_q;
        heldOp_d    = heldOp_q;
        heldCount_d = heldCount_q;
        heldHalf_d  = heldHalf_q;
        clk_d       = clk_q;
        manual_d    = manual_q;
        done_d      = 1'b0;
        finish_d    = finish_q;

        case (state_q)
            IDLE: begin
                manual_d = 1'b0;
                clk_d    = 1'b0;
            end
            FREE: begin
                edges_d = edges_q + ONE;
                if (accept) begin
                    state_d     = DRAIN;
                    heldOp_d    = cmd_op;
                    heldCount_d = cmd_count;
                    heldHalf_d  = cmd_half;
                    finish_d    = 1'b0;
                end
            end
            // Also reused to end STEP_N: manual drops only after nEnable has fallen.
            DRAIN: begin
                state_d  = IDLE;
                manual_d = 1'b0;
                clk_d    = 1'b0;
                finish_d = 1'b0;
                done_d   = finish_q;
            end
            RUN: begin
                edges_d = edges_q + ONE;
                if (pulseCnt_q <= ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    pulseCnt_d = pulseCnt_q - ONE;
                end
            end
            STEP_LO: begin
                if (halfCnt_q <= ONE) begin
                    state_d   = STEP_HI;
                    clk_d     = 1'b1;
                    halfCnt_d = halfLoad_q;
                    edges_d   = edges_q + ONE;
                end else begin
                    halfCnt_d = halfCnt_q - ONE;
                end
            end
            STEP_HI: begin
                if (halfCnt_q <= ONE) begin
                    clk_d = 1'b0;
                    if (pulseCnt_q <= ONE) begin
                        state_d  = DRAIN;
                        finish_d = 1'b1;
                    end else begin
                        state_d    = STEP_LO;
                        pulseCnt_d = pulseCnt_q - ONE;
                        halfCnt_d  = halfLoad_q;
                    end
                end else begin
                    halfCnt_d = halfCnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            edges_d = '0;
            case (launchOp)
                HALT: begin
                    state_d = IDLE;
                end
                FREE_RUN: begin
                    state_d = FREE;
                end
                RUN_N: begin
                    if (launchCount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        pulseCnt_d = launchCount;
                    end
                end
                STEP_N: begin
                    if (launchCount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = STEP_LO;
                        manual_d   = 1'b1;
                        clk_d      = 1'b0;
                        pulseCnt_d = launchCount;
                        halfLoad_d = launchH;
                        halfCnt_d  = launchH;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge tb_clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            pulseCnt_q  <= '0;
            halfCnt_q   <= '0;
            halfLoad_q  <= '0;
            edges_q     <= '0;
            heldOp_q    <= HALT;
            heldCount_q <= '0;
            heldHalf_q  <= '0;
            clk_q       <= 1'b0;
            manual_q    <= 1'b0;
            done_q      <= 1'b0;
            finish_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulseCnt_q  <= pulseCnt_d;
            halfCnt_q   <= halfCnt_d;
            halfLoad_q  <= halfLoad_d;
            edges_q     <= edges_d;
            heldOp_q    <= heldOp_d;
            heldCount_q <= heldCount_d;
            heldHalf_q  <= heldHalf_d;
            clk_q       <= clk_d;
            manual_q    <= manual_d;
            done_q      <= done_d;
            finish_q    <= finish_d;
            ready_q     <= 1'b1;
        end
    end

    // Retiming onto the falling edge keeps nEnable changes inside the tb_clk low phase.
    always_ff @(negedge tb_clk or negedge nReset) begin
        if (!nReset) begin
            nEnable_q <= 1'b0;
        end else begin
            nEnable_q <= enable;
        end
    end

endmodule

// File: tb/tb_clk_ctrl_seq.sv
// Scoreboard bench for clk_ctrl_seq: each RUN_N/STEP_N pushes its expected
// result at accept and the result is compared when done pulses.
module tb_clk_ctrl_seq;
    import clk_ctrl_seq_pkg::*;

    localparam int CNT_W = 16;

    logic             tbClk = 1'b0;
    logic             nReset;
    logic             cmdValid;
    logic             cmdReady;
    clk_cmd_e         cmdOp;
    logic [CNT_W-1:0] cmdCount;
    logic [CNT_W-1:0] cmdHalf;
    clk_ctrl_t        ctrlO;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] edges;
    logic             dutClk;
    logic             nEnMon;
    logic             manualMon;

    typedef struct {
        int expEdges;
        int expDut;
        int expLatency;
        int expBusy;
        int expClkHigh;
        int startCycle;
        int startDut;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    sbEntry_t popped;

    int checkCount  = 0;
    int passCount   = 0;
    int cycleCnt    = 0;
    int dutEdges    = 0;
    int busyAcc     = 0;
    int clkAcc      = 0;
    int acceptCycle = 0;
    int acceptDut   = 0;
    int nEnViol     = 0;
    int manualViol  = 0;
    bit reached;

    clk_ctrl_seq #(.CNT_W(CNT_W)) dut (
        .tb_clk    (tbClk),
        .nReset    (nReset),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_op    (cmdOp),
        .cmd_count (cmdCount),
        .cmd_half  (cmdHalf),
        .ctrl_o    (ctrlO),
        .busy      (busy),
        .done      (done),
        .edges     (edges)
    );

    always #5 tbClk = ~tbClk;

    // Reference model of the clock that test_if builds from the bundle.
    assign dutClk    = ctrlO.nEnable & (ctrlO.manual ? ctrlO.clk : tbClk);
    assign nEnMon    = ctrlO.nEnable;
    assign manualMon = ctrlO.manual;

    always @(posedge tbClk) cycleCnt++;
    always @(posedge dutClk) dutEdges++;
    always @(nEnMon) if (nReset && tbClk) nEnViol++;
    always @(manualMon) if (nReset && nEnMon) manualViol++;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic pushExpect(input clk_cmd_e op, input int count, input int half,
                              input bit viaDrain);
        sbEntry_t e;
        int h;
        int d;
        h = (half == 0) ? 1 : half;
        d = viaDrain ? 1 : 0;
        e.startCycle = cycleCnt;
        e.startDut   = dutEdges;
        if (count == 0) begin
            e.expEdges = 0; e.expDut = 0; e.expLatency = d; e.expBusy = 0; e.expClkHigh = 0;
        end else if (op == RUN_N) begin
            e.expEdges = count; e.expDut = count; e.expLatency = count + d;
            e.expBusy = count; e.expClkHigh = 0;
        end else begin
            e.expEdges = count; e.expDut = count; e.expLatency = 2 * count * h + 1 + d;
            e.expBusy = -1; e.expClkHigh = count * h;
        end
        sbQ.push_back(e);
        busyAcc = 0;
        clkAcc  = 0;
    endtask

    task automatic applyStimulus(input clk_cmd_e op, input int count, input int half,
                                 input bit viaDrain);
        bit gotReady;
        gotReady = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge tbClk);
            if (cmdReady) begin
                gotReady = 1'b1;
                break;
            end
        end
        if (!gotReady) begin
            checkOutput("readyTimeout", int'(cmdReady), 1);
            return;
        end
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdCount = count[CNT_W-1:0];
        cmdHalf  = half[CNT_W-1:0];
        @(posedge tbClk);
        #1;
        cmdValid    = 1'b0;
        acceptCycle = cycleCnt;
        acceptDut   = dutEdges;
        if (op == RUN_N || op == STEP_N) pushExpect(op, count, half, viaDrain);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sbQ.size() == 0) break;
            @(posedge tbClk);
        end
        #3;
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
    endtask

    always @(posedge tbClk) begin
        #2;
        busyAcc += int'(busy);
        clkAcc  += int'(ctrlO.clk);
        if (done) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", int'(done), 0);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("edgesAtDone", int'(edges), popped.expEdges);
                checkOutput("dutClkRises", dutEdges - popped.startDut, popped.expDut);
                checkOutput("doneLatency", cycleCnt - popped.startCycle, popped.expLatency);
                checkOutput("clkHighCycles", clkAcc, popped.expClkHigh);
                if (popped.expBusy >= 0) checkOutput("busyCycles", busyAcc, popped.expBusy);
            end
        end
    end

    initial begin
        nReset   = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = HALT;
        cmdCount = '0;
        cmdHalf  = '0;

        repeat (3) @(posedge tbClk);
        @(negedge tbClk);
        checkOutput("ctrlInReset", int'(ctrlO), 0);
        checkOutput("readyInReset", int'(cmdReady), 0);
        checkOutput("busyInReset", int'(busy), 0);
        checkOutput("doneInReset", int'(done), 0);
        checkOutput("edgesInReset", int'(edges), 0);
        nReset = 1'b1;
        #1 checkOutput("readyBeforeFirstEdge", int'(cmdReady), 0);
        @(posedge tbClk);
        #1;
        checkOutput("readyAfterRelease", int'(cmdReady), 1);
        checkOutput("dutFlatAfterReset", dutEdges, 0);
        checkOutput("ctrlAfterRelease", int'(ctrlO), 0);

        applyStimulus(RUN_N, 5, 0, 1'b0);
        waitIdle(40);
        checkOutput("ctrlIdleAfterRun", int'(ctrlO), 0);

        applyStimulus(STEP_N, 3, 2, 1'b0);
        waitIdle(60);
        checkOutput("ctrlIdleAfterStep", int'(ctrlO), 0);

        applyStimulus(FREE_RUN, 0, 0, 1'b0);
        repeat (10) @(posedge tbClk);
        #1;
        checkOutput("freeEdges", int'(edges), 10);
        checkOutput("freeDutRises", dutEdges - acceptDut, 10);
        applyStimulus(RUN_N, 2, 0, 1'b1);
        waitIdle(40);

        applyStimulus(RUN_N, 0, 0, 1'b0);
        waitIdle(20);
        applyStimulus(STEP_N, 0, 4, 1'b0);
        waitIdle(20);
        checkOutput("ctrlAfterStepZero", int'(ctrlO), 0);

        applyStimulus(STEP_N, 2, 0, 1'b0);
        waitIdle(40);

        applyStimulus(RUN_N, 4, 0, 1'b0);
        cmdValid = 1'b1;
        cmdOp    = RUN_N;
        cmdCount = 16'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge tbClk);
            if (done) break;
            checkOutput("readyDuringRun", int'(cmdReady), 0);
        end
        @(posedge tbClk);
        #1;
        cmdValid = 1'b0;
        pushExpect(RUN_N, 1, 0, 1'b0);
        waitIdle(40);

        applyStimulus(FREE_RUN, 0, 0, 1'b0);
        repeat (4) @(posedge tbClk);
        applyStimulus(HALT, 0, 0, 1'b1);
        repeat (3) @(posedge tbClk);
        #1;
        checkOutput("haltEdgesCleared", int'(edges), 0);
        checkOutput("haltCtrl", int'(ctrlO), 0);
        checkOutput("haltNoDutRise", dutEdges - acceptDut, 0);
        checkOutput("haltReady", int'(cmdReady), 1);

        applyStimulus(STEP_N, 3, 2, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge tbClk);
            if (int'(edges) == 2) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("stepReachedPulse2", int'(reached), 1);
        #2;
        nReset = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("ctrlAsyncReset", int'(ctrlO), 0);
        checkOutput("busyAsyncReset", int'(busy), 0);
        checkOutput("edgesAsyncReset", int'(edges), 0);
        checkOutput("readyAsyncReset", int'(cmdReady), 0);
        repeat (2) @(negedge tbClk);
        nReset = 1'b1;
        @(posedge tbClk);
        #1;
        checkOutput("edgesAfterReReset", int'(edges), 0);
        checkOutput("readyAfterReReset", int'(cmdReady), 1);

        applyStimulus(STEP_N, 1, 1, 1'b0);
        waitIdle(20);

        checkOutput("nEnableChangedWhileHigh", nEnViol, 0);
        checkOutput("manualChangedWhileEnabled", manualViol, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
